// File: rtl/audio_pkg.sv
// Shared constants for the audio sample FIFO slice.
// Default sample width, default depth and the level-counter width helper.
package audio_pkg;

   localparam int AUDIO_DATA_W         = 32;
   localparam int AUDIO_FIFO_DEPTH_DEF = 16;

   // Level must hold 0..DEPTH inclusive, hence one bit more than a pointer.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int AUDIO_LEVEL_W = level_w(AUDIO_FIFO_DEPTH_DEF);

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus one edge flop; rise_o pulses one clk cycle per rise.
// Ports: clk, rst_n (async low), async_i (level), rise_o (pulse). Flops reset to 1.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;

   always_comb begin
      s1_d = async_i;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // Reset high so a strobe already high at release is not seen as a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise_o = s2_q && !s3_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Sample FIFO between bus/DMA writes and an I2S transmitter frame strobe.
// Ports: MasterCLK, Reset_n, WrData/WrValid/WrReady, SyncCLK, OutputData,
// Level, Underrun, UnderrunClr; Irq only when AUDIO_FIFO_IRQ_EN is defined.
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH     = AUDIO_FIFO_DEPTH_DEF,
   parameter int DATA_W    = AUDIO_DATA_W,
   parameter int IRQ_LEVEL = DEPTH / 2
) (
   input  logic              MasterCLK,
   input  logic              Reset_n,
   input  logic [DATA_W-1:0] WrData,
   input  logic              WrValid,
   output logic              WrReady,
   input  logic              SyncCLK,
   output logic [DATA_W-1:0] OutputData,
   output logic [$clog2(DEPTH):0] Level,
   output logic              Underrun,
   input  logic              UnderrunClr
`ifdef AUDIO_FIFO_IRQ_EN
  ,output logic              Irq
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
       IRQ_LEVEL < 0 || IRQ_LEVEL > DEPTH) begin : g_bad_cfg
      $error("audio_sample_fifo: bad DEPTH or IRQ_LEVEL");
   end

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              underrun_q, underrun_d;
   logic              pop, empty, not_full, wr_en, rd_en;
   logic [DATA_W-1:0] mem_q [DEPTH];

   sync_edge_detect u_sync (
      .clk    (MasterCLK),
      .rst_n  (Reset_n),
      .async_i(SyncCLK),
      .rise_o (pop)
   );

   assign empty    = (level_q == '0);
   assign not_full = (level_q < LW'(DEPTH));
   assign wr_en    = WrValid && not_full;
   assign rd_en    = pop && !empty;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      out_d      = out_q;
      underrun_d = underrun_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      // An empty pop outputs silence; a write in the same cycle still lands.
      if (pop) begin
         if (empty) begin
            out_d = '0;
         end else begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
      end
      // Set after clear so a coincident underrun is never lost.
      if (UnderrunClr) underrun_d = 1'b0;
      if (pop && empty) underrun_d = 1'b1;
      unique case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge MasterCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         out_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         out_q      <= out_d;
         underrun_q <= underrun_d;
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge MasterCLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= WrData;
   end

   assign WrReady    = not_full;
   assign OutputData = out_q;
   assign Level      = level_q;
   assign Underrun   = underrun_q;

`ifdef AUDIO_FIFO_IRQ_EN
   logic irq_q, irq_d;

   // Registered from the next level so Irq lines up with Level.
   assign irq_d = (level_d <= LW'(IRQ_LEVEL));

   always_ff @(posedge MasterCLK or negedge Reset_n) begin
      if (!Reset_n) irq_q <= 1'b0;
      else          irq_q <= irq_d;
   end

   assign Irq = irq_q;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: queue model plus directed pins.
// Honours AUDIO_FIFO_IRQ_EN for the Irq port and its checks.
module tb_audio_sample_fifo;
   import audio_pkg::*;

   localparam int DEPTH     = 16;
   localparam int IRQ_LEVEL = DEPTH / 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [31:0]              wr_data = '0;
   logic                     wr_valid = 1'b0;
   logic                     wr_ready;
   logic                     sync = 1'b0;
   logic [31:0]              out_data;
   logic [AUDIO_LEVEL_W-1:0] level;
   logic                     unr;
   logic                     uclr = 1'b0;
`ifdef AUDIO_FIFO_IRQ_EN
   logic                     irq;
`endif

   int total = 0;
   int bad   = 0;

   audio_sample_fifo dut (
      .MasterCLK  (clk),
      .Reset_n    (rst_n),
      .WrData     (wr_data),
      .WrValid    (wr_valid),
      .WrReady    (wr_ready),
      .SyncCLK    (sync),
      .OutputData (out_data),
      .Level      (level),
      .Underrun   (unr),
      .UnderrunClr(uclr)
`ifdef AUDIO_FIFO_IRQ_EN
     ,.Irq        (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue; a SyncCLK rise seen at one edge
   // becomes a pop two edges later (three cycles after the rise).
   logic [31:0] mq[$];
   logic [31:0] m_out = '0;
   logic        m_unr = 1'b0;
   logic        m_irq = 1'b0;
   logic [2:0]  hist  = 3'b111;
   bit          m_pop, m_wr, m_empty;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_out = '0;
         m_unr = 1'b0;
         m_irq = 1'b0;
         hist  = 3'b111;
      end else begin
         m_pop   = hist[1] && !hist[2];
         m_empty = (mq.size() == 0);
         m_wr    = wr_valid && (mq.size() < DEPTH);
         if (m_pop) m_out = m_empty ? 32'h0 : mq.pop_front();
         if (uclr) m_unr = 1'b0;
         if (m_pop && m_empty) m_unr = 1'b1;
         if (m_wr) mq.push_back(wr_data);
         hist  = {hist[1:0], sync};
         m_irq = (mq.size() <= IRQ_LEVEL);
      end
   end

   always @(posedge clk) begin
      #2;
      chk("level", 32'(level), 32'(mq.size()));
      chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
      chk("out_data", out_data, m_out);
      chk("underrun", 32'(unr), 32'(m_unr));
`ifdef AUDIO_FIFO_IRQ_EN
      chk("irq", 32'(irq), 32'(m_irq));
`endif
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      uclr     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wr(input logic [31:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic pop_req();
      sync = 1'b1;
      repeat (3) @(negedge clk);
      sync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int p;
      // Reset state and first pop latency.
      do_reset();
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out", out_data, 32'h0);
      chk("rst_unr", 32'(unr), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      wr(32'h1111_2222);
      wr(32'h3333_4444);
      chk("two_writes_level", 32'(level), 32'd2);
      sync = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("pop_not_early", out_data, 32'h0);
      @(posedge clk);
      #1 chk("pop_3cyc_out", out_data, 32'h1111_2222);
      chk("pop_3cyc_level", 32'(level), 32'd1);
      @(negedge clk);
      sync = 1'b0;
      repeat (3) @(negedge clk);

      // Fill past full with WrValid held high.
      do_reset();
      wr_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_data = 32'hA000_0000 + 32'(i);
         @(negedge clk);
         if (i == 15) chk("full_wr_ready", 32'(wr_ready), 32'd0);
      end
      wr_valid = 1'b0;
      chk("full_level", 32'(level), 32'd16);
      pop_req();
      chk("full_first_out", out_data, 32'hA000_0000);
      chk("full_after_pop", 32'(level), 32'd15);
      for (int i = 0; i < 15; i++) pop_req();
      chk("drain_last", out_data, 32'hA000_000F);
      chk("drain_level", 32'(level), 32'd0);

      // Underrun and its clear.
      pop_req();
      chk("unr_out", out_data, 32'h0);
      chk("unr_set", 32'(unr), 32'd1);
      uclr = 1'b1;
      @(negedge clk);
      uclr = 1'b0;
      chk("unr_clr", 32'(unr), 32'd0);
      sync = 1'b1;
      repeat (2) @(negedge clk);
      uclr = 1'b1;
      @(negedge clk);
      uclr = 1'b0;
      chk("unr_set_wins", 32'(unr), 32'd1);
      sync = 1'b0;
      repeat (3) @(negedge clk);

      // Simultaneous write and pop at level 5.
      do_reset();
      for (int i = 0; i < 5; i++) wr(32'hB000_0000 + 32'(i));
      chk("lvl5", 32'(level), 32'd5);
      sync = 1'b1;
      repeat (2) @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 32'hC000_0000;
      @(negedge clk);
      wr_valid = 1'b0;
      chk("simul_level", 32'(level), 32'd5);
      chk("simul_out", out_data, 32'hB000_0000);

      // Reset mid-frame with SyncCLK held high.
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_out", out_data, 32'h0);
      chk("midrst_unr", 32'(unr), 32'd0);
      sync = 1'b0;
      repeat (3) @(negedge clk);
      pop_req();
      chk("midrst_first_unr", 32'(unr), 32'd1);
      chk("midrst_first_out", out_data, 32'h0);

`ifdef AUDIO_FIFO_IRQ_EN
      do_reset();
      for (int i = 0; i < 9; i++) wr(32'hD000_0000 + 32'(i));
      chk("irq_at9", 32'(irq), 32'd0);
      pop_req();
      chk("irq_lvl8", 32'(level), 32'd8);
      chk("irq_at8", 32'(irq), 32'd1);
      wr(32'hD000_00FF);
      chk("irq_back9", 32'(irq), 32'd0);
`endif

      // Randomised traffic with phases biased toward full and empty.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         unique case ((c / 500) % 3)
            0:       p = 85;
            1:       p = 15;
            default: p = 50;
         endcase
         wr_valid = ($urandom_range(0, 99) < p);
         wr_data  = $urandom;
         if ($urandom_range(0, 3) == 0) sync = ~sync;
         uclr  = ($urandom_range(0, 7) == 0);
         rst_n = ($urandom_range(0, 1499) != 0);
      end
      rst_n    = 1'b1;
      wr_valid = 1'b0;
      uclr     = 1'b0;
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
